// File: rtl/mem_stage.sv
// mem_stage: MIPS memory stage; EX/MEM register plus a req/ready MainRAM access FSM
//   CLK, RST_N        clock, synchronous active-low reset
//   *E, *_in          execute-stage controls and values, captured when stall_out=0
//   *M, *_out         registered values to write-back / fetch
//   mem_*             MainRAM request, write-enable, address, data, ready
//   stall_out         freezes PC, IF/ID and ID/EX while an access is outstanding
//   mem_timeout_err   sticky flag: an access waited TIMEOUT_CYCLES without mem_ready
//   misalign_err      sticky flag, only with MEM_ALIGN_CHECK_EN: unaligned lw/sw dropped
module mem_stage #(
  parameter int ADDR_W = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              RegWriteE,
  input  logic              MemtoRegE,
  input  logic              MemWriteE,
  input  logic              BranchE,
  input  logic              JumpE,
  input  logic [5:0]        ALUopE,
  input  logic [31:0]       ALUOut_in,
  input  logic [31:0]       WriteData_in,
  input  logic [31:0]       PCPlus4_in,
  input  logic [31:0]       PCBranch_in,
  input  logic [4:0]        wb_addr_in,
  output logic              RegWriteM,
  output logic              MemtoRegM,
  output logic              BranchM,
  output logic              JumpM,
  output logic [5:0]        ALUopM,
  output logic [31:0]       ALUOut_out,
  output logic [31:0]       PCPlus4_out,
  output logic [31:0]       PCBranch_out,
  output logic [31:0]       ReadData_out,
  output logic [4:0]        wb_addr_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              stall_out,
  output logic              mem_timeout_err
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic              misalign_err
`endif
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state, nextState;
  logic regWrite, memtoReg, memWrite, branch, jump;
  logic [5:0] aluOp;
  logic [31:0] aluOut, writeData, pcPlus4, pcBranch;
  logic [4:0] wbAddr;
  logic [CW-1:0] waitCnt;
  logic access, timeoutHit, memopE, misalignNow;
  assign access = state == ACCESS;
  assign timeoutHit = access & ~mem_ready & (waitCnt == CW'(TIMEOUT_CYCLES - 1));
  assign stall_out = access & ~mem_ready & ~timeoutHit;
`ifdef MEM_ALIGN_CHECK_EN
  // an unaligned memop is captured but never enters ACCESS, so a memop sitting in IDLE is one
  assign memopE = (MemtoRegE | MemWriteE) & (ALUOut_in[1:0] == 2'b00);
  assign misalignNow = ~access & (memtoReg | memWrite);
  always_ff @(posedge CLK)
    if (!RST_N) misalign_err <= 1'b0;
    else if (misalignNow) misalign_err <= 1'b1;
`else
  assign memopE = MemtoRegE | MemWriteE;
  assign misalignNow = 1'b0;
`endif
  always_comb nextState = stall_out ? state : (memopE ? ACCESS : IDLE);
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= IDLE;
      {regWrite, memtoReg, memWrite, branch, jump} <= '0;
      aluOp <= '0;
      {aluOut, writeData, pcPlus4, pcBranch} <= '0;
      wbAddr <= '0;
      waitCnt <= '0;
      mem_timeout_err <= 1'b0;
    end else begin
      state <= nextState;
      if (!stall_out) begin
        {regWrite, memtoReg, memWrite, branch, jump} <= {RegWriteE, MemtoRegE, MemWriteE, BranchE, JumpE};
        aluOp <= ALUopE;
        {aluOut, writeData, pcPlus4, pcBranch} <= {ALUOut_in, WriteData_in, PCPlus4_in, PCBranch_in};
        wbAddr <= wb_addr_in;
      end
      waitCnt <= stall_out ? waitCnt + 1'b1 : '0;
      if (timeoutHit) mem_timeout_err <= 1'b1;
    end
  end
  // gating with stall_out makes WB see each instruction exactly once, on its completing cycle
  assign RegWriteM = regWrite & ~stall_out & ~timeoutHit & ~misalignNow;
  assign BranchM = branch & ~stall_out;
  assign JumpM = jump & ~stall_out;
  assign MemtoRegM = memtoReg;
  assign ALUopM = aluOp;
  assign ALUOut_out = aluOut;
  assign PCPlus4_out = pcPlus4;
  assign PCBranch_out = pcBranch;
  assign wb_addr_out = wbAddr;
  assign ReadData_out = (access & mem_ready) ? mem_rdata : 32'h0;
  assign mem_req = access;
  assign mem_we = access & memWrite;
  assign mem_addr = access ? ADDR_W'(aluOut) : '0;
  assign mem_wdata = access ? writeData : 32'h0;
endmodule
